// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and field layout for the SPI command controller.
//   opcode_e  - command opcodes (values 7..15 are illegal)
//   state_e   - controller FSM states
//   *_LSB/_W  - packet field offsets and widths (same for command and response)
//   ST_*      - bit positions inside the 4-bit status field
package spi_cmd_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_WRITE     = 4'd1,
    OP_READ      = 4'd2,
    OP_WRITE_INC = 4'd3,
    OP_READ_INC  = 4'd4,
    OP_SET_PTR   = 4'd5,
    OP_STATUS    = 4'd6
  } opcode_e;

  typedef enum logic [1:0] {IDLE, DECODE, MEM_WAIT, RESPOND} state_e;

  localparam int OP_LSB   = 36;
  localparam int OP_W     = 4;
  localparam int ST_LSB   = 32;
  localparam int ST_W     = 4;
  localparam int ADDR_LSB = 24;
  localparam int ADDR_W   = 8;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 24;

  localparam int ST_TIMEOUT = 3;
  localparam int ST_OVERRUN = 2;
  localparam int ST_ILLEGAL = 1;

  function automatic logic is_mem_op(logic [OP_W-1:0] op);
    return (op == OP_WRITE) || (op == OP_READ) ||
           (op == OP_WRITE_INC) || (op == OP_READ_INC);
  endfunction

  function automatic logic is_inc_op(logic [OP_W-1:0] op);
    return (op == OP_WRITE_INC) || (op == OP_READ_INC);
  endfunction

  function automatic logic is_write_op(logic [OP_W-1:0] op);
    return (op == OP_WRITE) || (op == OP_WRITE_INC);
  endfunction

  function automatic logic is_illegal_op(logic [OP_W-1:0] op);
    return op > OP_STATUS;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: coefficient/parameter memory bus.
//   master (controller): drives mem_addr, mem_wdata, mem_we, mem_req;
//                        receives mem_rdata, mem_ack
//   slave  (memory)    : the mirror image
interface spi_cmd_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_req;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master(output mem_addr, mem_wdata, mem_we, mem_req,
                 input  mem_rdata, mem_ack);
  modport slave (input  mem_addr, mem_wdata, mem_we, mem_req,
                 output mem_rdata, mem_ack);
endinterface

// File: rtl/spi_cmd_timeout.sv
// spi_cmd_timeout: counts consecutive cycles with run high.
//   clk, reset : clock, synchronous active-high reset
//   run        : high while the controller waits for mem_ack
//   expired    : high in the TIMEOUT_CYCLES-th consecutive run cycle
module spi_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Cleared whenever the wait ends so every access starts from zero.
  always_ff @(posedge clk) begin
    if (reset || !run) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes 40-bit SPI command packets, performs memory
// accesses and returns a 40-bit response packet.
//   clk, reset         : clock, synchronous active-high reset
//   rx_data / rx_ready : command packet + one-cycle valid pulse
//   tx_data / tx_load  : response packet + one-cycle load pulse
//   busy               : controller not idle
//   mem                : memory bus (spi_cmd_ctrl_if.master)
// Build option: SPI_CMD_CTRL_TIMEOUT_EN adds a mem_ack timeout.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int PACKET_WIDTH   = 40,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_WIDTH-1:0] rx_data,
  input  logic                    rx_ready,
  output logic [PACKET_WIDTH-1:0] tx_data,
  output logic                    tx_load,
  output logic                    busy,
  spi_cmd_ctrl_if.master          mem
);

  state_e             state, state_nxt;
  logic [OP_W-1:0]    op;
  logic [ADDR_W-1:0]  pkt_addr, eff_addr, ptr;
  logic [DATA_W-1:0]  pkt_data, rsp_data;
  logic               flg_to, flg_ov, flg_il;
  logic               set_to, set_ov, set_il;
  logic [ST_W-1:0]    status_now;
  logic               timeout_hit;
  logic               unused_rsvd;

  assign unused_rsvd = ^rx_data[ST_LSB +: ST_W];

`ifdef SPI_CMD_CTRL_TIMEOUT_EN
  spi_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .run    (state == MEM_WAIT),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_to    = 1'b0;
    set_il    = 1'b0;
    // Any packet arriving outside IDLE (including the RESPOND cycle) is lost.
    set_ov    = rx_ready && (state != IDLE);
    case (state)
      IDLE:     if (rx_ready) state_nxt = DECODE;
      DECODE: begin
        set_il    = is_illegal_op(op);
        state_nxt = is_mem_op(op) ? MEM_WAIT : RESPOND;
      end
      MEM_WAIT: begin
        // A real ack wins over a timeout expiring in the same cycle.
        if (mem.mem_ack) state_nxt = RESPOND;
        else if (timeout_hit) begin
          state_nxt = RESPOND;
          set_to    = 1'b1;
        end
      end
      RESPOND:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign status_now = {flg_to | set_to, flg_ov | set_ov, flg_il | set_il, 1'b0};
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      op            <= '0;
      pkt_addr      <= '0;
      pkt_data      <= '0;
      eff_addr      <= '0;
      rsp_data      <= '0;
      ptr           <= '0;
      flg_to        <= 1'b0;
      flg_ov        <= 1'b0;
      flg_il        <= 1'b0;
      tx_data       <= '0;
      tx_load       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      tx_load <= 1'b0;

      // STATUS clears after reporting; flags raised this same cycle survive.
      if (state == RESPOND && op == OP_STATUS) begin
        flg_to <= set_to;
        flg_ov <= set_ov;
        flg_il <= set_il;
      end else begin
        flg_to <= flg_to | set_to;
        flg_ov <= flg_ov | set_ov;
        flg_il <= flg_il | set_il;
      end

      case (state)
        IDLE: if (rx_ready) begin
          op       <= rx_data[OP_LSB   +: OP_W];
          pkt_addr <= rx_data[ADDR_LSB +: ADDR_W];
          pkt_data <= rx_data[DATA_LSB +: DATA_W];
        end
        DECODE: begin
          eff_addr <= is_inc_op(op) ? ptr : pkt_addr;
          rsp_data <= is_write_op(op) ? pkt_data : '0;
          if (op == OP_SET_PTR) begin
            ptr      <= pkt_addr;
            rsp_data <= DATA_W'(pkt_addr);
          end
          if (is_mem_op(op)) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_write_op(op);
            mem.mem_addr  <= ADDR_WIDTH'(is_inc_op(op) ? ptr : pkt_addr);
            mem.mem_wdata <= DATA_WIDTH'(pkt_data);
          end
        end
        MEM_WAIT: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            if (!mem.mem_we) rsp_data <= DATA_W'(mem.mem_rdata);
            if (is_inc_op(op)) ptr <= ptr + 1'b1;
          end else if (timeout_hit) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            rsp_data    <= '0;
          end
        end
        RESPOND: begin
          tx_load <= 1'b1;
          tx_data <= PACKET_WIDTH'({op, status_now, eff_addr, rsp_data});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 40, serial packet width in bits; fixed at 40 for the command format below.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 24, memory data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait for mem_ack.
REQ-005 SHALL have port clk  input  1  system clock; one clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port rx_data  input  PACKET_WIDTH  received command packet from the serdes.
REQ-008 SHALL have port rx_ready  input  1  one-cycle pulse; rx_data valid.
REQ-009 SHALL have port tx_data  output  PACKET_WIDTH  response packet to the serdes.
REQ-010 SHALL have port tx_load  output  1  one-cycle pulse; serdes captures tx_data.
REQ-011 SHALL have ports mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_we (output, 1), mem_req (output, 1), mem_rdata (input, DATA_WIDTH), mem_ack (input, 1) for coefficient/parameter memory access.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Command layout SHALL be [39:36] opcode, [35:32] reserved (ignored), [31:24] address, [23:0] data.
REQ-014 Opcodes SHALL be: 0 NOP, 1 WRITE, 2 READ, 3 WRITE_INC, 4 READ_INC, 5 SET_PTR, 6 STATUS; 7-15 illegal.
REQ-015 Response layout SHALL be [39:36] echoed opcode, [35:32] status {timeout, overrun, illegal, 0}, [31:24] effective address, [23:0] data (read data, write data echo, pointer, or zero).
REQ-016 FSM states SHALL be IDLE, DECODE, MEM_WAIT, RESPOND.
REQ-017 IDLE: rx_ready high -> latch rx_data, go to DECODE next cycle.
REQ-018 DECODE: WRITE/READ/WRITE_INC/READ_INC -> MEM_WAIT; NOP/SET_PTR/STATUS/illegal -> RESPOND.
REQ-019 *_INC opcodes SHALL use the internal 8-bit pointer as address, ignoring packet address; the pointer increments by 1 on mem_ack and wraps 255 -> 0.
REQ-020 SET_PTR SHALL load the pointer from packet address; the response data field carries the new pointer value.
REQ-021 MEM_WAIT: mem_req held high with stable mem_addr/mem_wdata/mem_we until the cycle mem_ack is sampled high; mem_req drops the following cycle; mem_rdata is captured in the ack cycle.
REQ-022 Minimum command latency SHALL be 4 cycles from rx_ready to tx_load when mem_ack responds in the first MEM_WAIT cycle; it is 3 cycles for non-memory opcodes.
REQ-023 RESPOND: tx_load high for exactly one cycle with tx_data valid, then return to IDLE.
REQ-024 An illegal opcode SHALL set the sticky illegal flag and produce no memory access.
REQ-025 rx_ready while state is not IDLE SHALL drop that packet and set the sticky overrun flag; rx_ready coincident with the RESPOND -> IDLE transition is also dropped.
REQ-026 STATUS SHALL report the sticky flags in the status field, then clear all sticky flags; flags set in that same cycle remain set.
REQ-027 The status field of every response SHALL show the current sticky flags.

Reset
REQ-028 reset SHALL force state IDLE, pointer 0, sticky flags 0, tx_data 0, tx_load 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0 at the next clk edge.
REQ-029 reset during MEM_WAIT SHALL abandon the access; a late mem_ack after reset is ignored.

Configuration
REQ-030 Macro SPI_CMD_CTRL_TIMEOUT_EN defined: a counter runs in MEM_WAIT; after TIMEOUT_CYCLES cycles without mem_ack the FSM drops mem_req, sets the sticky timeout flag, leaves the pointer unchanged, responds with data 0, and goes to RESPOND.
REQ-031 Macro undefined: no counter; MEM_WAIT waits indefinitely; the timeout status bit reads 0.

Structure
REQ-032 A shared package spi_cmd_pkg SHALL hold the opcode enum, state enum, the status-bit positions and the packet field offsets/widths.
REQ-033 The timeout counter SHALL be a sub-module spi_cmd_timeout, instantiated only under SPI_CMD_CTRL_TIMEOUT_EN.

Verification
REQ-034 WRITE 0x1_0_12_ABCDEF with ack after 2 cycles -> mem_addr 0x12, mem_wdata 0xABCDEF, mem_we 1; tx_data 0x1012ABCDEF.
REQ-035 SET_PTR address 0xFF, then READ_INC x2 returning 0x000001 and 0x000002 -> addresses 0xFF then 0x00; responses 0x40FF000001 and 0x4000000002.
REQ-036 Opcode 0xA -> no mem_req; response status bit 1 set; a following STATUS response reads 0x6_2_00_000000; the next STATUS reads status 0.
REQ-037 rx_ready pulses while in MEM_WAIT -> second packet dropped; overrun flag set in the first response.
REQ-038 With SPI_CMD_CTRL_TIMEOUT_EN and mem_ack never asserted -> mem_req drops after 255 cycles; response data 0 with status bit 3 set.
REQ-039 reset asserted mid MEM_WAIT -> mem_req 0 and busy 0 at the next edge; a later mem_ack produces no tx_load.
